// File: rtl/rect_rasterizer.sv
// rect_rasterizer: fills a clipped screen rectangle with a flat colour or a scaled sprite; define RECT_RASTERIZER_TRANSPARENCY_EN to skip texels equal to 12'hF0F
module rect_rasterizer #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int FB_ADDR_W         = 19,
  parameter int TEX_ADDR_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic [TEX_ADDR_W+58:0] op,
  input  logic                   op_valid,
  output logic                   op_ready,
  output logic                   tex_en,
  output logic [TEX_ADDR_W-1:0]  tex_addr,
  input  logic [11:0]            tex_data,
  output logic                   fb_we,
  output logic [FB_ADDR_W-1:0]   fb_addr,
  output logic [11:0]            fb_data
);
  // op bus layout, first field in the MSBs
  typedef struct packed {
    logic [10:0]           x;
    logic [10:0]           y;
    logic [10:0]           width;
    logic [10:0]           height;
    logic [11:0]           color;
    logic                  mem_en;
    logic [TEX_ADDR_W-1:0] mem_addr;
    logic [1:0]            scale;
  } gpu_op_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t               state_q, state_d;
  gpu_op_t              op_in, op_q, op_d;
  logic [10:0]          cx_q, cx_d, cy_q, cy_d;
  logic                 last_col;
  logic [11:0]          sx, sy;
  logic [21:0]          tex_off;
  logic [FB_ADDR_W-1:0] pix_addr, s1_addr_q, fb_addr_q;
  logic                 s1_v_q, s1_v_d, s1_mem_q, s2_v_q, s2_v_d;
  logic [11:0]          fb_data_q;

  assign op_in    = op;
  assign op_ready = state_q == IDLE;
  assign tex_en   = ce;
  assign fb_we    = s2_v_q & ce;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign last_col = cx_q == op_q.width - 11'd1;
  // 12-bit screen coordinates cannot wrap for any 11-bit origin and offset
  assign sx       = {1'b0, op_q.x} + {1'b0, cx_q};
  assign sy       = {1'b0, op_q.y} + {1'b0, cy_q};
  assign pix_addr = FB_ADDR_W'(32'(sy) * HOR_ACTIVE_PIXELS + 32'(sx));
  assign s1_v_d   = state_q == RUN && 32'(sx) < HOR_ACTIVE_PIXELS && 32'(sy) < VER_ACTIVE_PIXELS;
  // shifting both the position and the sprite width replicates each texel 2^scale times
  assign tex_off  = 22'(cy_q >> op_q.scale) * 22'(op_q.width >> op_q.scale) + 22'(cx_q >> op_q.scale);
  assign tex_addr = (state_q == RUN && op_q.mem_en) ? op_q.mem_addr + TEX_ADDR_W'(tex_off) : '0;
`ifdef RECT_RASTERIZER_TRANSPARENCY_EN
  assign s2_v_d   = s1_v_q && !(s1_mem_q && tex_data == 12'hF0F);
`else
  assign s2_v_d   = s1_v_q;
`endif

  // accept, row-major scan and drain sequencing
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (state_q == IDLE) begin
      if (op_valid) begin
        op_d    = op_in;
        cx_d    = '0;
        cy_d    = '0;
        state_d = (op_in.width == '0 || op_in.height == '0) ? DRAIN : RUN;
      end
    end else if (state_q == RUN) begin
      cx_d = last_col ? 11'd0 : cx_q + 11'd1;
      cy_d = last_col ? cy_q + 11'd1 : cy_q;
      if (last_col && cy_q == op_q.height - 11'd1) state_d = DRAIN;
    end else begin
      state_d = IDLE;
    end
  end

  // control state advances only on enabled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else if (ce) begin
      state_q <= state_d;
      op_q    <= op_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  // stage 1 tracks the pixel whose texel is in flight; stage 2 holds the framebuffer write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_mem_q  <= 1'b0;
      s1_addr_q <= '0;
      s2_v_q    <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else if (ce) begin
      s1_v_q    <= s1_v_d;
      s1_mem_q  <= op_q.mem_en;
      s1_addr_q <= pix_addr;
      s2_v_q    <= s2_v_d;
      fb_addr_q <= s1_addr_q;
      fb_data_q <= s1_mem_q ? tex_data : op_q.color;
    end
  end
endmodule

// File: tb/tb_rect_rasterizer.sv
// tb_rect_rasterizer: directed checks of fills, sprites, scaling, clipping, clock enable and reset
module tb_rect_rasterizer;
  localparam int FW = 19;
  localparam int TW = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b1;
  logic          op_valid = 1'b0;
  logic [TW+58:0] op = '0;
  logic          op_ready, tex_en, fb_we;
  logic [TW-1:0] tex_addr;
  logic [11:0]   tex_data = '0;
  logic [11:0]   fb_data;
  logic [FW-1:0] fb_addr;
  int            errors = 0;
  int            checks = 0;
  logic [FW-1:0] wa[$];
  logic [11:0]   wd[$];
  logic [TW-1:0] ta[$];

  rect_rasterizer dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .tex_en(tex_en), .tex_addr(tex_addr), .tex_data(tex_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 clk = ~clk;

  // sprite memory: one-cycle read latency, texel = low address bits xor F0F (address 0 gives F0F)
  always @(posedge clk) if (tex_en) tex_data <= tex_addr[11:0] ^ 12'hF0F;

  // record framebuffer writes and issued texel addresses away from the active edge
  always @(negedge clk) begin
    if (fb_we) begin
      wa.push_back(fb_addr);
      wd.push_back(fb_data);
    end
    if (ce && !op_ready) ta.push_back(tex_addr);
  end

  function automatic logic [TW+58:0] pack_op(input logic [10:0] ox, input logic [10:0] oy,
      input logic [10:0] ow, input logic [10:0] oh, input logic [11:0] col, input logic me,
      input logic [TW-1:0] ma, input logic [1:0] sc);
    return {ox, oy, ow, oh, col, me, ma, sc};
  endfunction

  // called at posedge+1; returns ce cycles from accept to op_ready (-1 on timeout), then flushes
  task automatic send_op(input logic [TW+58:0] o, input bit tog, output int cyc);
    int guard;
    wa.delete(); wd.delete(); ta.delete();
    op = o; op_valid = 1'b1; ce = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; cyc = 1; guard = 0;
    while (op_ready !== 1'b1 && guard < 20000) begin
      if (tog) ce = ~ce;
      @(posedge clk); #1;
      guard++;
      if (ce) cyc++;
    end
    if (op_ready !== 1'b1) cyc = -1;
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset op_ready: got %b want 1", op_ready); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset fb_we: got %b want 0", fb_we); end
    checks++; if (fb_addr !== '0) begin errors++; $display("FAIL reset fb_addr: got %0d want 0", fb_addr); end
    checks++; if (fb_data !== '0) begin errors++; $display("FAIL reset fb_data: got %h want 000", fb_data); end
    checks++; if (tex_addr !== '0) begin errors++; $display("FAIL reset tex_addr: got %0d want 0", tex_addr); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset release op_ready: got %b want 1", op_ready); end
  endtask

  task automatic test_full_width();
    int cyc, bad;
    send_op(pack_op(11'd0, 11'd0, 11'd640, 11'd8, 12'h000, 1'b0, 16'd0, 2'd0), 1'b0, cyc);
    checks++; if (cyc != 5122) begin errors++; $display("FAIL full_width latency: got %0d want 5122", cyc); end
    checks++; if (wa.size() != 5120) begin errors++; $display("FAIL full_width writes: got %0d want 5120", wa.size()); end
    bad = -1;
    foreach (wa[i]) if (bad < 0 && (wa[i] !== FW'(i) || wd[i] !== 12'h000)) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL full_width seq: index %0d addr %0d data %h want addr %0d data 000", bad, wa[bad], wd[bad], bad);
    end
  endtask

  task automatic test_sprite();
    int cyc, n, bad, t, ea, first, expn;
    bit seen, want_seen;
    logic [11:0] ed;
    send_op(pack_op(11'd20, 11'd228, 11'd34, 11'd24, 12'h000, 1'b1, 16'd0, 2'd0), 1'b0, cyc);
    checks++; if (cyc != 818) begin errors++; $display("FAIL sprite latency: got %0d want 818", cyc); end
`ifdef RECT_RASTERIZER_TRANSPARENCY_EN
    expn = 815; first = 145941; want_seen = 1'b0;
`else
    expn = 816; first = 145940; want_seen = 1'b1;
`endif
    n = 0; bad = -1;
    for (int cy = 0; cy < 24; cy++)
      for (int cx = 0; cx < 34; cx++) begin
        t = cy * 34 + cx;
        if (t == 0 && !want_seen) continue;
        ea = (228 + cy) * 640 + 20 + cx;
        ed = 12'(t) ^ 12'hF0F;
        if (bad < 0 && (n >= wa.size() || wa[n] !== FW'(ea) || wd[n] !== ed)) bad = n;
        n++;
      end
    checks++; if (wa.size() != expn) begin errors++; $display("FAIL sprite writes: got %0d want %0d", wa.size(), expn); end
    checks++; if (bad >= 0) begin errors++; $display("FAIL sprite seq: first bad write index %0d of %0d", bad, wa.size()); end
    checks++;
    if (wa.size() == 0 || wa[0] !== FW'(first)) begin
      errors++; $display("FAIL sprite first fb_addr: got %0d want %0d", wa.size() ? wa[0] : '0, first);
    end
    seen = 1'b0;
    foreach (wa[i]) if (wa[i] === FW'(145940)) seen = 1'b1;
    checks++; if (seen !== want_seen) begin errors++; $display("FAIL sprite F0F texel write: got %b want %b", seen, want_seen); end
    bad = -1;
    for (int i = 0; i < 816; i++) if (bad < 0 && (i >= ta.size() || ta[i] !== TW'(i))) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL sprite tex_addr: first bad index %0d want %0d", bad, bad); end
  endtask

  task automatic test_scale();
    int cyc, bad, et;
    send_op(pack_op(11'd0, 11'd0, 11'd40, 11'd72, 12'h000, 1'b1, 16'd100, 2'd3), 1'b0, cyc);
    checks++; if (cyc != 2882) begin errors++; $display("FAIL scale latency: got %0d want 2882", cyc); end
    checks++; if (ta.size() < 2880) begin errors++; $display("FAIL scale tex log: got %0d want >= 2880", ta.size()); end
    else begin
      checks++; if (ta[7] !== 16'd100) begin errors++; $display("FAIL scale cx7: got %0d want 100", ta[7]); end
      checks++; if (ta[8] !== 16'd101) begin errors++; $display("FAIL scale cx8: got %0d want 101", ta[8]); end
      checks++; if (ta[320] !== 16'd105) begin errors++; $display("FAIL scale row8: got %0d want 105", ta[320]); end
    end
    checks++; if (wa.size() != 2880) begin errors++; $display("FAIL scale writes: got %0d want 2880", wa.size()); end
    bad = -1;
    for (int cy = 0; cy < 72; cy++)
      for (int cx = 0; cx < 40; cx++) begin
        et = 100 + (cy / 8) * 5 + cx / 8;
        if (bad < 0 && (cy * 40 + cx >= wa.size() || cy * 40 + cx >= ta.size() || ta[cy * 40 + cx] !== TW'(et) ||
            wa[cy * 40 + cx] !== FW'(cy * 640 + cx) || wd[cy * 40 + cx] !== (12'(et) ^ 12'hF0F))) bad = cy * 40 + cx;
      end
    checks++; if (bad >= 0) begin errors++; $display("FAIL scale seq: first bad pixel index %0d", bad); end
  endtask

  task automatic test_clip();
    int cyc, bad, n;
    send_op(pack_op(11'd620, 11'd470, 11'd40, 11'd20, 12'h3C5, 1'b0, 16'd0, 2'd0), 1'b0, cyc);
    checks++; if (cyc != 802) begin errors++; $display("FAIL clip latency: got %0d want 802", cyc); end
    checks++; if (wa.size() != 200) begin errors++; $display("FAIL clip writes: got %0d want 200", wa.size()); end
    bad = -1; n = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 20; c++) begin
        if (bad < 0 && (n >= wa.size() || wa[n] !== FW'((470 + r) * 640 + 620 + c) || wd[n] !== 12'h3C5)) bad = n;
        n++;
      end
    checks++; if (bad >= 0) begin errors++; $display("FAIL clip seq: first bad write index %0d", bad); end
  endtask

  task automatic test_ce_toggle();
    int cyc, bad;
    send_op(pack_op(11'd5, 11'd2, 11'd4, 11'd4, 12'hABC, 1'b0, 16'd0, 2'd0), 1'b1, cyc);
    checks++; if (cyc != 18) begin errors++; $display("FAIL ce_toggle latency: got %0d want 18", cyc); end
    checks++; if (wa.size() != 16) begin errors++; $display("FAIL ce_toggle writes: got %0d want 16", wa.size()); end
    bad = -1;
    for (int i = 0; i < 16; i++)
      if (bad < 0 && (i >= wa.size() || wa[i] !== FW'((2 + i / 4) * 640 + 5 + i % 4) || wd[i] !== 12'hABC)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL ce_toggle seq: first bad write index %0d", bad); end
  endtask

  task automatic test_zero_size();
    int cyc;
    send_op(pack_op(11'd7, 11'd7, 11'd0, 11'd5, 12'hFFF, 1'b0, 16'd0, 2'd0), 1'b0, cyc);
    checks++; if (cyc != 2) begin errors++; $display("FAIL zero_w latency: got %0d want 2", cyc); end
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL zero_w writes: got %0d want 0", wa.size()); end
    send_op(pack_op(11'd7, 11'd7, 11'd5, 11'd0, 12'hFFF, 1'b1, 16'd9, 2'd0), 1'b0, cyc);
    checks++; if (cyc != 2) begin errors++; $display("FAIL zero_h latency: got %0d want 2", cyc); end
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL zero_h writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_busy_ignore();
    int guard, bad;
    wa.delete(); wd.delete(); ta.delete();
    op = pack_op(11'd1, 11'd1, 11'd3, 11'd2, 12'h111, 1'b0, 16'd0, 2'd0); op_valid = 1'b1;
    @(posedge clk); #1;
    op = pack_op(11'd50, 11'd50, 11'd5, 11'd5, 12'h222, 1'b0, 16'd0, 2'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL busy poll op_ready: got %b want 0", op_ready); end
    guard = 0;
    while (op_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL busy completion: got %b want 1", op_ready); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (wa.size() != 6) begin errors++; $display("FAIL busy writes: got %0d want 6", wa.size()); end
    bad = -1;
    for (int i = 0; i < 6; i++)
      if (bad < 0 && (i >= wa.size() || wa[i] !== FW'((1 + i / 3) * 640 + 1 + i % 3) || wd[i] !== 12'h111)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL busy seq: first bad write index %0d", bad); end
  endtask

  task automatic test_reset_mid();
    int cyc, bad;
    op = pack_op(11'd10, 11'd10, 11'd10, 11'd10, 12'h777, 1'b0, 16'd0, 2'd0); op_valid = 1'b1; ce = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL reset_mid pre fb_we: got %b want 1", fb_we); end
    rst_n = 1'b0; #1;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_mid fb_we: got %b want 0", fb_we); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_mid op_ready: got %b want 1", op_ready); end
    checks++; if (fb_addr !== '0) begin errors++; $display("FAIL reset_mid fb_addr: got %0d want 0", fb_addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_op(pack_op(11'd100, 11'd100, 11'd2, 11'd2, 12'h0F0, 1'b0, 16'd0, 2'd0), 1'b0, cyc);
    checks++; if (cyc != 6) begin errors++; $display("FAIL reset_mid new op latency: got %0d want 6", cyc); end
    checks++; if (wa.size() != 4) begin errors++; $display("FAIL reset_mid writes: got %0d want 4", wa.size()); end
    bad = -1;
    for (int i = 0; i < 4; i++)
      if (bad < 0 && (i >= wa.size() || wa[i] !== FW'((100 + i / 2) * 640 + 100 + i % 2) || wd[i] !== 12'h0F0)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL reset_mid seq: first bad write index %0d", bad); end
  endtask

  initial begin
    test_reset();
    test_full_width();
    test_sprite();
    test_scale();
    test_clip();
    test_ce_toggle();
    test_zero_size();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
